// File: rtl/ipid_slice_collector.sv
// ipid_slice_collector: packs 16-bit IP-ID slices into 256-bit signatures and streams them out in order.
// Optional per-slice even-parity checking is enabled with `define SLICE_PARITY_EN.
`default_nettype none

module ipid_slice_collector #(
  parameter int SLICE_W = 16,
  parameter int SIG_W   = 256,
  parameter int DEPTH   = 10,
  parameter int IDX_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               slice_valid,
  input  logic [SLICE_W-1:0] slice_data,
  input  logic               slice_par,
  output logic               sig_valid,
  input  logic               sig_ready,
  output logic [SIG_W-1:0]   sig_data,
  output logic [IDX_W-1:0]   sig_idx,
  output logic [IDX_W-1:0]   sigs_stored,
  output logic               busy,
  output logic               done,
  output logic               err_overflow,
  output logic               err_parity
);

  localparam int NSL   = SIG_W / SLICE_W;
  localparam int CNT_W = (NSL > 1) ? $clog2(NSL) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t                   state, state_nxt;
  logic [SIG_W-SLICE_W-1:0] shreg;
  logic [SIG_W-1:0]         buffer [DEPTH];
  logic [SIG_W-1:0]         next_sig;
  logic [IDX_W-1:0]         wr_idx, rd_idx;
  logic [CNT_W-1:0]         slice_cnt;
  logic                     ovf_flag;
  logic                     par_bad;
  logic                     session_clr, shift_en, write_en, drop, set_ovf, consume;

  assign next_sig = {shreg, slice_data};

`ifdef SLICE_PARITY_EN
  logic par_flag;
  assign par_bad    = ^{slice_data, slice_par};
  assign err_parity = par_flag;
`else
  logic unused_par;
  assign unused_par = slice_par;
  assign par_bad    = 1'b0;
  assign err_parity = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    session_clr = 1'b0;
    shift_en    = 1'b0;
    write_en    = 1'b0;
    drop        = 1'b0;
    set_ovf     = 1'b0;
    consume     = sig_valid && sig_ready;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt   = COLLECT;
          session_clr = 1'b1;
        end
      end
      COLLECT: begin
        if (slice_valid) begin
          if (par_bad) begin
            drop = 1'b1;
          end else begin
            shift_en = 1'b1;
            if (slice_cnt == CNT_W'(NSL - 1)) begin
              write_en = 1'b1;
              if (wr_idx == IDX_W'(DEPTH - 1)) state_nxt = DRAIN;
            end
          end
        end
      end
      DRAIN: begin
        set_ovf = slice_valid;
        if (consume && rd_idx == IDX_W'(DEPTH - 1)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
    // abort overrides everything, including an in-flight consume
    if (abort) begin
      state_nxt   = IDLE;
      session_clr = 1'b0;
      shift_en    = 1'b0;
      write_en    = 1'b0;
      drop        = 1'b0;
      set_ovf     = 1'b0;
      consume     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg     <= '0;
      slice_cnt <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      ovf_flag  <= 1'b0;
`ifdef SLICE_PARITY_EN
      par_flag  <= 1'b0;
`endif
    end else if (abort) begin
      shreg     <= '0;
      slice_cnt <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
    end else if (session_clr) begin
      shreg     <= '0;
      slice_cnt <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      ovf_flag  <= 1'b0;
`ifdef SLICE_PARITY_EN
      par_flag  <= 1'b0;
`endif
    end else begin
      if (shift_en) begin
        shreg     <= next_sig[SIG_W-SLICE_W-1:0];
        slice_cnt <= write_en ? '0 : slice_cnt + 1'b1;
      end
      if (drop) begin
        slice_cnt <= '0;
`ifdef SLICE_PARITY_EN
        par_flag  <= 1'b1;
`endif
      end
      if (write_en) wr_idx <= wr_idx + 1'b1;
      if (consume)  rd_idx <= rd_idx + 1'b1;
      if (set_ovf)  ovf_flag <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (write_en) buffer[wr_idx] <= next_sig;
  end

  // gate the read so stale buffer contents never reach the port
  assign sig_valid    = (rd_idx < wr_idx);
  assign sig_data     = sig_valid ? buffer[rd_idx] : '0;
  assign sig_idx      = rd_idx;
  assign sigs_stored  = wr_idx;
  assign busy         = (state == COLLECT) || (state == DRAIN);
  assign done         = (state == DONE);
  assign err_overflow = ovf_flag;

endmodule

`default_nettype wire
